branch_resolve_ctrl: RTL and testbench



---
 rtl/bp_pkg.sv | 26 ++
 rtl/br_inflight_fifo.sv | 63 ++++++
 rtl/branch_resolve_ctrl.sv | 127 ++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch resolve controller: FSM encoding and
// the layout of one in-flight branch record.
package bp_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_FLUSH = 1'b1;

    typedef enum logic {
        IDLE  = ST_IDLE,
        FLUSH = ST_FLUSH
    } br_state_e;

    localparam int unsigned BR_ENTRY_W   = 65;
    localparam int unsigned BR_PC1_LSB   = 0;
    localparam int unsigned BR_ADDR_LSB  = 32;
    localparam int unsigned BR_TAKEN_BIT = 64;

    function automatic logic [BR_ENTRY_W-1:0] br_pack(
        input logic        taken,
        input logic [31:0] addr,
        input logic [31:0] pc_1
    );
        return {taken, addr, pc_1};
    endfunction

endpackage

// File: rtl/br_inflight_fifo.sv
// Synchronous FIFO for in-flight branch records; occupancy counter decides
// full/empty so pointers can wrap freely.
module br_inflight_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 65
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clear,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot being written when full
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Tracks predicted branches from fetch to EX, trains the predictor on each
// resolution and runs a flush/redirect sequence on mispredicts.
module branch_resolve_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_branch,
    input  logic                    if_pred_taken,
    input  logic [31:0]             if_pred_addr,
    input  logic [31:0]             if_pc_1,
    input  logic                    ex_valid,
    input  logic                    ex_taken,
    input  logic [31:0]             ex_target,
    output logic                    upd_taken,
    output logic                    upd_not_taken,
    output logic                    stall_if,
    output logic                    flush,
    output logic                    redirect_valid,
    output logic [31:0]             redirect_pc,
    output logic [$clog2(DEPTH):0]  inflight,
    output logic                    err
);

    localparam int unsigned FCNT_W = $clog2(FLUSH_CYCLES) + 1;

    br_state_e         r_state;
    logic [FCNT_W-1:0] r_flush_cnt;
    logic              r_upd_taken;
    logic              r_upd_not_taken;
    logic              r_flush;
    logic              r_redirect_valid;
    logic [31:0]       r_redirect_pc;
    logic              r_err;

    logic [BR_ENTRY_W-1:0]  w_head;
    logic [$clog2(DEPTH):0] w_count;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_idle;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_mispredict;
    logic                   w_err;
    logic                   w_head_taken;
    logic [31:0]            w_head_addr;
    logic [31:0]            w_head_pc1;

    assign w_head_taken = w_head[BR_TAKEN_BIT];
    assign w_head_addr  = w_head[BR_ADDR_LSB +: 32];
    assign w_head_pc1   = w_head[BR_PC1_LSB +: 32];

    assign w_idle       = (r_state == IDLE);
    assign w_pop        = w_idle & ex_valid & ~w_empty;
    assign w_mispredict = w_pop & ((w_head_taken != ex_taken) |
                                   (ex_taken & w_head_taken & (w_head_addr != ex_target)));
    // A fetch coinciding with a mispredict is on the wrong path
    assign w_push       = w_idle & if_branch & ~w_mispredict & (~w_full | w_pop);
    assign w_err        = w_idle & ((if_branch & w_full & ~w_pop) | (ex_valid & w_empty));

    br_inflight_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BR_ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_mispredict),
        .i_wdata (br_pack(if_pred_taken, if_pred_addr, if_pc_1)),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_flush_cnt      <= '0;
            r_upd_taken      <= 1'b0;
            r_upd_not_taken  <= 1'b0;
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_err            <= 1'b0;
        end else begin
            r_upd_taken      <= w_pop & ex_taken;
            r_upd_not_taken  <= w_pop & ~ex_taken;
            r_err            <= w_err;
            r_redirect_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_mispredict) begin
                        r_state          <= FLUSH;
                        r_flush          <= 1'b1;
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= ex_taken ? ex_target : w_head_pc1;
                        r_flush_cnt      <= FCNT_W'(FLUSH_CYCLES - 1);
                    end
                end
                FLUSH: begin
                    if (r_flush_cnt == '0) begin
                        r_state <= IDLE;
                        r_flush <= 1'b0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - FCNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign upd_taken      = r_upd_taken;
    assign upd_not_taken  = r_upd_not_taken;
    assign stall_if       = w_full;
    assign flush          = r_flush;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign inflight       = w_count;
    assign err            = r_err;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench: directed scenarios then random traffic, compared each
// cycle against a queue-based model of the branch tracking rules.
module tb_branch_resolve_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned FC    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_branch;
    logic        if_pred_taken;
    logic [31:0] if_pred_addr;
    logic [31:0] if_pc_1;
    logic        ex_valid;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        upd_taken;
    logic        upd_not_taken;
    logic        stall_if;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [$clog2(DEPTH):0] inflight;
    logic        err;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(
        .DEPTH        (DEPTH),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_branch      (if_branch),
        .if_pred_taken  (if_pred_taken),
        .if_pred_addr   (if_pred_addr),
        .if_pc_1        (if_pc_1),
        .ex_valid       (ex_valid),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .upd_taken      (upd_taken),
        .upd_not_taken  (upd_not_taken),
        .stall_if       (stall_if),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inflight       (inflight),
        .err            (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        pt;
        logic [31:0] pa;
        logic [31:0] pc1;
    } ent_t;

    ent_t        mq[$];
    int          m_flush_left = 0;
    logic        e_upd_t = 1'b0;
    logic        e_upd_nt = 1'b0;
    logic        e_err = 1'b0;
    logic        e_rv = 1'b0;
    logic [31:0] e_rpc = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // Model of one clock edge, reading the inputs currently applied
    task automatic model_step();
        bit   pop;
        bit   push;
        ent_t h;
        if (rst) begin
            mq.delete();
            m_flush_left = 0;
            e_upd_t = 0; e_upd_nt = 0; e_err = 0; e_rv = 0; e_rpc = '0;
            return;
        end
        e_upd_t = 0; e_upd_nt = 0; e_err = 0; e_rv = 0;
        if (m_flush_left > 0) begin
            m_flush_left--;
            return;
        end
        pop   = ex_valid && mq.size() > 0;
        push  = if_branch && (mq.size() < DEPTH || pop);
        e_err = (if_branch && mq.size() == DEPTH && !pop) || (ex_valid && mq.size() == 0);
        if (pop) begin
            h = mq.pop_front();
            e_upd_t  = ex_taken;
            e_upd_nt = !ex_taken;
            if (h.pt != ex_taken || (ex_taken && h.pa != ex_target)) begin
                mq.delete();
                m_flush_left = FC;
                e_rv  = 1;
                e_rpc = ex_taken ? ex_target : h.pc1;
                push  = 0;
            end
        end
        if (push) mq.push_back('{if_pred_taken, if_pred_addr, if_pc_1});
    endtask

    task automatic cyc(input logic r, input logic b, input logic pt, input logic [31:0] pa,
                       input logic [31:0] pc, input logic ev, input logic et,
                       input logic [31:0] tg);
        rst = r; if_branch = b; if_pred_taken = pt; if_pred_addr = pa; if_pc_1 = pc;
        ex_valid = ev; ex_taken = et; ex_target = tg;
        @(posedge clk);
        model_step();
        #1;
        check_eq("upd_taken",      32'(upd_taken),      32'(e_upd_t));
        check_eq("upd_not_taken",  32'(upd_not_taken),  32'(e_upd_nt));
        check_eq("err",            32'(err),            32'(e_err));
        check_eq("flush",          32'(flush),          32'(m_flush_left > 0));
        check_eq("redirect_valid", 32'(redirect_valid), 32'(e_rv));
        check_eq("redirect_pc",    redirect_pc,         e_rpc);
        check_eq("inflight",       32'(inflight),       32'(mq.size()));
        check_eq("stall_if",       32'(stall_if),       32'(mq.size() == DEPTH));
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic enq(input logic pt, input logic [31:0] pa, input logic [31:0] pc);
        cyc(0, 1, pt, pa, pc, 0, 0, 0);
    endtask

    task automatic res(input logic et, input logic [31:0] tg);
        cyc(0, 0, 0, 0, 0, 1, et, tg);
    endtask

    // Resolve the model's head as correctly predicted, optionally enqueuing too
    task automatic res_ok(input logic b, input logic [31:0] pa, input logic [31:0] pc);
        logic et;
        logic [31:0] tg;
        et = (mq.size() > 0) ? mq[0].pt : 1'b0;
        tg = (mq.size() > 0) ? mq[0].pa : 32'h0;
        cyc(0, b, 1'b1, pa, pc, 1, et, tg);
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // Correct taken prediction
        enq(1, 32'h100, 32'h0C4);
        res(1, 32'h100);
        idle();

        // Direction mispredict, fetches during flush are ignored
        enq(1, 32'h200, 32'h044);
        res(0, 32'h0);
        enq(1, 32'h600, 32'h604);
        enq(0, 32'h700, 32'h704);
        idle();

        // Target mispredict
        enq(1, 32'h300, 32'h010);
        res(1, 32'h340);
        idle();
        idle();
        idle();

        // Fill, overflow, then push+pop while full and drain in order
        enq(1, 32'h1000, 32'h1004);
        enq(0, 32'h2000, 32'h2004);
        enq(1, 32'h3000, 32'h3004);
        enq(0, 32'h4000, 32'h4004);
        enq(1, 32'h5000, 32'h5004);
        res_ok(1, 32'h6000, 32'h6004);
        res_ok(1, 32'h7000, 32'h7004);
        for (int i = 0; i < 4; i++) res_ok(0, 0, 0);
        idle();

        // Underflow
        res(1, 32'h0);
        idle();

        // Reset in the middle of recovery
        enq(0, 32'h0, 32'h080);
        res(1, 32'h500);
        idle();
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic        r, b, pt, ev, et;
            logic [31:0] pa, pc, tg;
            r  = ($urandom_range(0, 63) == 0);
            b  = ($urandom_range(0, 1) == 1);
            pt = ($urandom_range(0, 1) == 1);
            pa = 32'($urandom_range(1, 2)) << 8;
            pc = $urandom;
            ev = ($urandom_range(0, 9) < 4);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                et = mq[0].pt;
                tg = mq[0].pa;
            end else begin
                et = ($urandom_range(0, 1) == 1);
                tg = 32'($urandom_range(1, 2)) << 8;
            end
            cyc(r, b, pt, pa, pc, ev, et, tg);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
